// File: rtl/ips2l_pcie_dma_rx_mwr_dec_pkg.sv
// rtl/ips2l_pcie_dma_rx_mwr_dec_pkg.sv - shared constants and types for the RX MWr decoder
package ips2l_pcie_dma_rx_mwr_dec_pkg;

  localparam logic [2:0] FMT_MWR32 = 3'b010;
  localparam logic [2:0] FMT_MWR64 = 3'b011;
  localparam logic [4:0] TYPE_MEM  = 5'b00000;

  // header bit positions within the 128-bit header beat
  localparam int FMT_MSB  = 31;
  localparam int FMT_LSB  = 29;
  localparam int TYPE_MSB = 28;
  localparam int TYPE_LSB = 24;
  localparam int EP_BIT   = 14;
  localparam int LEN_MSB  = 9;
  localparam int LEN_LSB  = 0;
  localparam int LBE_MSB  = 39;
  localparam int LBE_LSB  = 36;
  localparam int FBE_MSB  = 35;
  localparam int FBE_LSB  = 32;
  localparam int DW2_LSB  = 64;
  localparam int DW3_LSB  = 96;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PAY3  = 3'd1,
    ST_PAY4  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DROP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ALIGN_PASS  = 2'd0,
    ALIGN_SHIFT = 2'd1,
    ALIGN_FLUSH = 2'd2
  } align_sel_t;

endpackage

// File: rtl/ips2l_pcie_dma_rx_mwr_dec_if.sv
// rtl/ips2l_pcie_dma_rx_mwr_dec_if.sv - RX TLP stream in, decoded MWr write burst out
interface ips2l_pcie_dma_rx_mwr_dec_if;
  logic         i_axis_rx_tvalid;
  logic         o_axis_rx_tready;
  logic [127:0] i_axis_rx_tdata;
  logic         i_axis_rx_tlast;
  logic [1:0]   i_axis_rx_bar_hit;
  logic         o_wr_start;
  logic [9:0]   o_length;
  logic [7:0]   o_dwbe;
  logic [127:0] o_data;
  logic [3:0]   o_dw_vld;
  logic [63:0]  o_addr;
  logic [1:0]   o_bar_hit;
  logic         o_drop;
  logic         o_rx_err;

  modport master (
    output i_axis_rx_tvalid, i_axis_rx_tdata, i_axis_rx_tlast, i_axis_rx_bar_hit,
    input  o_axis_rx_tready, o_wr_start, o_length, o_dwbe, o_data, o_dw_vld,
           o_addr, o_bar_hit, o_drop, o_rx_err
  );

  modport slave (
    input  i_axis_rx_tvalid, i_axis_rx_tdata, i_axis_rx_tlast, i_axis_rx_bar_hit,
    output o_axis_rx_tready, o_wr_start, o_length, o_dwbe, o_data, o_dw_vld,
           o_addr, o_bar_hit, o_drop, o_rx_err
  );
endinterface

// File: rtl/ips2l_pcie_dma_rx_dw_align.sv
// rtl/ips2l_pcie_dma_rx_dw_align.sv - carry DW register, 3DW/4DW lane mux and DW-valid mask
module ips2l_pcie_dma_rx_dw_align
  import ips2l_pcie_dma_rx_mwr_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         carry_en,
  input  align_sel_t   sel,
  input  logic [127:0] data_in,
  input  logic [9:0]   rem,
  output logic [127:0] data_out,
  output logic [3:0]   dw_vld
);

  logic [31:0] carry;

  // with a 3DW header the top DW of every beat belongs to the next output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= '0;
    end else if (carry_en) begin
      carry <= data_in[127:96];
    end
  end

  always_comb begin
    data_out = data_in;
    case (sel)
      ALIGN_SHIFT: data_out = {data_in[95:0], carry};
      ALIGN_FLUSH: data_out = {96'b0, carry};
      default:     data_out = data_in;
    endcase
  end

  always_comb begin
    dw_vld = 4'b0000;
    if (rem >= 10'd4) begin
      dw_vld = 4'b1111;
    end else begin
      case (rem[1:0])
        2'b01:   dw_vld = 4'b0001;
        2'b10:   dw_vld = 4'b0011;
        2'b11:   dw_vld = 4'b0111;
        default: dw_vld = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/ips2l_pcie_dma_rx_mwr_dec.sv
// rtl/ips2l_pcie_dma_rx_mwr_dec.sv - extracts MWr TLPs from the 128-bit RX stream as packed write bursts
// Optional: PCIE_RX_MWR_POISON_DROP_EN discards MWr TLPs with EP set.
module ips2l_pcie_dma_rx_mwr_dec
  import ips2l_pcie_dma_rx_mwr_dec_pkg::*;
#(
  parameter logic [9:0] MAX_PAYLOAD_DW = 10'd256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ips2l_pcie_dma_rx_mwr_dec_if.slave   bus
);

  state_t       state, state_nxt;
  align_sel_t   sel;
  logic         tready_q, wr_q, err_q, drop_q;
  logic         wr_nxt, err_nxt, drop_nxt, carry_en, rem_dec, hdr_load;
  logic [9:0]   rem, len_q;
  logic [7:0]   dwbe_q;
  logic [63:0]  addr_q;
  logic [1:0]   bar_q;
  logic [127:0] data_q, align_data;
  logic [3:0]   vld_q, align_vld;

  logic [127:0] tdata;
  logic         tlast, accept;
  logic [2:0]   hdr_fmt;
  logic [4:0]   hdr_type;
  logic [9:0]   hdr_len;
  logic         is_mwr, len_ok, poison, hdr_ok, hdr_4dw;

  assign tdata    = bus.i_axis_rx_tdata;
  assign tlast    = bus.i_axis_rx_tlast;
  assign accept   = bus.i_axis_rx_tvalid & tready_q;
  assign hdr_fmt  = tdata[FMT_MSB:FMT_LSB];
  assign hdr_type = tdata[TYPE_MSB:TYPE_LSB];
  assign hdr_len  = tdata[LEN_MSB:LEN_LSB];
  assign hdr_4dw  = (hdr_fmt == FMT_MWR64);
  assign is_mwr   = (hdr_type == TYPE_MEM) && ((hdr_fmt == FMT_MWR32) || hdr_4dw);
  // a length field of 0 encodes 1024 DW, always beyond the supported payload
  assign len_ok   = (hdr_len != 10'd0) && (hdr_len <= MAX_PAYLOAD_DW);
`ifdef PCIE_RX_MWR_POISON_DROP_EN
  assign poison   = tdata[EP_BIT];
`else
  assign poison   = 1'b0;
`endif
  assign hdr_ok   = is_mwr && len_ok && !poison;

  always_comb begin
    state_nxt = state;
    sel       = ALIGN_PASS;
    wr_nxt    = 1'b0;
    err_nxt   = 1'b0;
    drop_nxt  = 1'b0;
    carry_en  = 1'b0;
    rem_dec   = 1'b0;
    hdr_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (hdr_ok) begin
            hdr_load = 1'b1;
            if (hdr_4dw) begin
              state_nxt = ST_PAY4;
            end else begin
              carry_en  = 1'b1;
              state_nxt = tlast ? ST_FLUSH : ST_PAY3;
            end
          end else begin
            drop_nxt  = 1'b1;
            state_nxt = tlast ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_PAY3: begin
        if (accept) begin
          wr_nxt   = 1'b1;
          sel      = ALIGN_SHIFT;
          carry_en = 1'b1;
          rem_dec  = 1'b1;
          if (tlast) begin
            state_nxt = (len_q[1:0] == 2'b01) ? ST_FLUSH : ST_IDLE;
          end
        end else begin
          err_nxt = 1'b1;
        end
      end
      ST_PAY4: begin
        if (accept) begin
          wr_nxt  = 1'b1;
          rem_dec = 1'b1;
          if (tlast) begin
            state_nxt = ST_IDLE;
          end
        end else begin
          err_nxt = 1'b1;
        end
      end
      ST_FLUSH: begin
        wr_nxt    = 1'b1;
        sel       = ALIGN_FLUSH;
        rem_dec   = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_DROP: begin
        if (accept && tlast) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  ips2l_pcie_dma_rx_dw_align u_align (
    .clk      (clk),
    .rst_n    (rst_n),
    .carry_en (carry_en),
    .sel      (sel),
    .data_in  (tdata),
    .rem      (rem),
    .data_out (align_data),
    .dw_vld   (align_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tready_q <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      data_q   <= '0;
      vld_q    <= '0;
      rem      <= '0;
      len_q    <= '0;
      dwbe_q   <= '0;
      addr_q   <= '0;
      bar_q    <= '0;
    end else begin
      state    <= state_nxt;
      tready_q <= (state_nxt != ST_FLUSH);
      wr_q     <= wr_nxt;
      err_q    <= err_nxt;
      drop_q   <= drop_nxt;
      if (wr_nxt) begin
        data_q <= align_data;
        vld_q  <= align_vld;
      end else begin
        vld_q  <= 4'b0000;
      end
      if (hdr_load) begin
        rem    <= hdr_len;
        len_q  <= hdr_len;
        dwbe_q <= {tdata[LBE_MSB:LBE_LSB], tdata[FBE_MSB:FBE_LSB]};
        bar_q  <= bus.i_axis_rx_bar_hit;
        addr_q <= hdr_4dw ? {tdata[DW2_LSB +: 32], tdata[DW3_LSB+2 +: 30], 2'b00}
                          : {32'b0, tdata[DW2_LSB+2 +: 30], 2'b00};
      end else if (rem_dec) begin
        rem <= (rem > 10'd4) ? rem - 10'd4 : 10'd0;
      end
    end
  end

  assign bus.o_axis_rx_tready = tready_q;
  assign bus.o_wr_start       = wr_q;
  assign bus.o_length         = len_q;
  assign bus.o_dwbe           = dwbe_q;
  assign bus.o_data           = data_q;
  assign bus.o_dw_vld         = vld_q;
  assign bus.o_addr           = addr_q;
  assign bus.o_bar_hit        = bar_q;
  assign bus.o_drop           = drop_q;
  assign bus.o_rx_err         = err_q;

endmodule

// File: tb/tb_ips2l_pcie_dma_rx_mwr_dec.sv
// tb/tb_ips2l_pcie_dma_rx_mwr_dec.sv - directed table-driven bench for the RX MWr decoder
module tb_ips2l_pcie_dma_rx_mwr_dec;

`ifdef PCIE_RX_MWR_POISON_DROP_EN
  localparam bit POISON_DROP = 1'b1;
`else
  localparam bit POISON_DROP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ips2l_pcie_dma_rx_mwr_dec_if rx();

  ips2l_pcie_dma_rx_mwr_dec #(.MAX_PAYLOAD_DW(10'd256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rx)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [9:0]  len;
    logic        ep;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [63:0] addr;
    logic [1:0]  bar;
    int          pay_dw;
    bit          exp_wr;
    int          exp_beats;
    logic [3:0]  exp_last_vld;
    int          exp_flush;
  } vec_t;

  vec_t vecs[12];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] mon_data[$];
  logic [3:0]   mon_vld[$];
  int           mon_drop, mon_err, mon_bursts, mon_flush, first_cyc;
  logic         prev_ws;
  logic [63:0]  mon_addr;
  logic [9:0]   mon_len;
  logic [7:0]   mon_be;
  logic [1:0]   mon_bar;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx.o_wr_start) begin
        if (!prev_ws) begin
          mon_bursts++;
          if (first_cyc < 0) first_cyc = cyc;
          mon_addr = rx.o_addr;
          mon_len  = rx.o_length;
          mon_be   = rx.o_dwbe;
          mon_bar  = rx.o_bar_hit;
        end
        mon_data.push_back(rx.o_data);
        mon_vld.push_back(rx.o_dw_vld);
      end
      if (rx.o_drop) mon_drop++;
      if (rx.o_rx_err) mon_err++;
      if (!rx.o_axis_rx_tready) mon_flush++;
      prev_ws = rx.o_wr_start;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    mon_data.delete();
    mon_vld.delete();
    mon_drop = 0; mon_err = 0; mon_bursts = 0; mon_flush = 0;
    first_cyc = -1; prev_ws = rx.o_wr_start;
  endtask

  function automatic logic [31:0] pay(input logic [15:0] seed, input int idx);
    return {seed, 16'(idx)};
  endfunction

  task automatic put_beat(input logic [127:0] d, input logic [1:0] bar, input logic last,
                          output int acc_cyc);
    int n = 0;
    @(negedge clk);
    rx.i_axis_rx_tvalid  = 1'b1;
    rx.i_axis_rx_tdata   = d;
    rx.i_axis_rx_tlast   = last;
    rx.i_axis_rx_bar_hit = bar;
    while (!rx.o_axis_rx_tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("tready_timeout", 0, 1);
    acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx.i_axis_rx_tvalid = 1'b0;
    rx.i_axis_rx_tlast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_tlp(input vec_t v, input logic [15:0] seed, input int gap_at, output int hdr_cyc);
    logic [31:0]  dw0, dw1;
    logic [127:0] beat;
    int idx, b, dummy;
    dw0 = {v.fmt, v.typ, 9'd0, v.ep, 4'd0, v.len};
    dw1 = {24'h000100, v.lbe, v.fbe};
    if (v.fmt[0]) begin
      beat = {v.addr[31:0], v.addr[63:32], dw1, dw0};
      idx = 0;
    end else begin
      beat = {(v.pay_dw > 0) ? pay(seed, 0) : 32'h0, v.addr[31:0], dw1, dw0};
      idx = (v.pay_dw > 0) ? 1 : 0;
    end
    put_beat(beat, v.bar, idx >= v.pay_dw, hdr_cyc);
    b = 1;
    while (idx < v.pay_dw) begin
      beat = '0;
      for (int j = 0; j < 4; j++) begin
        if (idx < v.pay_dw) begin
          beat[32*j +: 32] = pay(seed, idx);
          idx++;
        end
      end
      if (b == gap_at) begin
        @(negedge clk);
        rx.i_axis_rx_tvalid = 1'b0;
      end
      put_beat(beat, 2'b00, idx >= v.pay_dw, dummy);
      b++;
    end
  endtask

  task automatic check_beats(input string nm, input vec_t v, input logic [15:0] seed);
    logic [3:0]   ev;
    logic [127:0] ed, ad;
    for (int k = 0; k < mon_data.size() && k < v.exp_beats; k++) begin
      ev = (k == v.exp_beats - 1) ? v.exp_last_vld : 4'hF;
      ed = '0;
      ad = mon_data[k];
      for (int j = 0; j < 4; j++) begin
        if (ev[j]) ed[32*j +: 32] = pay(seed, 4*k + j);
        else       ad[32*j +: 32] = 32'h0;
      end
      chk($sformatf("%s.vld%0d", nm, k), mon_vld[k], ev);
      chk($sformatf("%s.data%0d", nm, k), ad, ed);
    end
  endtask

  task automatic check_case(input string nm, input vec_t v, input logic [15:0] seed, input int hdr_cyc);
    logic [63:0] exp_addr;
    chk({nm, ".drop"}, mon_drop, v.exp_wr ? 0 : 1);
    chk({nm, ".err"}, mon_err, 0);
    chk({nm, ".bursts"}, mon_bursts, v.exp_wr ? 1 : 0);
    chk({nm, ".beats"}, mon_data.size(), v.exp_beats);
    chk({nm, ".flush"}, mon_flush, v.exp_flush);
    if (v.exp_wr) begin
      exp_addr = v.fmt[0] ? {v.addr[63:2], 2'b00} : {32'h0, v.addr[31:2], 2'b00};
      chk({nm, ".latency"}, first_cyc, hdr_cyc + 2);
      chk({nm, ".addr"}, mon_addr, exp_addr);
      chk({nm, ".len"}, mon_len, v.len);
      chk({nm, ".dwbe"}, mon_be, {v.lbe, v.fbe});
      chk({nm, ".bar"}, mon_bar, v.bar);
      check_beats(nm, v, seed);
    end
  endtask

  initial begin
    int hc, hc2;
    vec_t v;
    rx.i_axis_rx_tvalid  = 1'b0;
    rx.i_axis_rx_tdata   = '0;
    rx.i_axis_rx_tlast   = 1'b0;
    rx.i_axis_rx_bar_hit = 2'b00;

    // fmt typ len ep fbe lbe addr bar pay_dw | exp_wr beats last_vld flush
    vecs[0]  = '{3'b010, 5'd0, 10'd1,   1'b0, 4'hF, 4'h0, 64'h10,             2'd1, 1,   1'b1, 1,  4'b0001, 1};
    vecs[1]  = '{3'b010, 5'd0, 10'd5,   1'b0, 4'hF, 4'hF, 64'h100,            2'd0, 5,   1'b1, 2,  4'b0001, 1};
    vecs[2]  = '{3'b011, 5'd0, 10'd8,   1'b0, 4'hF, 4'hF, 64'h1_0000_0040,    2'd2, 8,   1'b1, 2,  4'b1111, 0};
    vecs[3]  = '{3'b000, 5'd0, 10'd1,   1'b0, 4'hF, 4'h0, 64'h200,            2'd0, 0,   1'b0, 0,  4'b0000, 0};
    vecs[4]  = '{3'b011, 5'd0, 10'd4,   1'b0, 4'hF, 4'hF, 64'h2_0000_0000,    2'd1, 4,   1'b1, 1,  4'b1111, 0};
    vecs[5]  = '{3'b010, 5'd0, 10'd0,   1'b0, 4'hF, 4'hF, 64'h300,            2'd0, 6,   1'b0, 0,  4'b0000, 0};
    vecs[6]  = '{3'b010, 5'd0, 10'd3,   1'b0, 4'hF, 4'hF, 64'h2000,           2'd3, 3,   1'b1, 1,  4'b0111, 0};
    vecs[7]  = '{3'b010, 5'd0, 10'd257, 1'b0, 4'hF, 4'hF, 64'h400,            2'd0, 6,   1'b0, 0,  4'b0000, 0};
    vecs[8]  = '{3'b010, 5'd0, 10'd256, 1'b0, 4'hF, 4'hF, 64'h8000,           2'd0, 256, 1'b1, 64, 4'b1111, 0};
    vecs[9]  = '{3'b010, 5'd0, 10'd2,   1'b1, 4'hF, 4'hF, 64'h500,            2'd2, 2,
                 !POISON_DROP, POISON_DROP ? 0 : 1, POISON_DROP ? 4'b0000 : 4'b0011, 0};
    vecs[10] = '{3'b010, 5'd10, 10'd2,  1'b0, 4'hF, 4'hF, 64'h600,            2'd0, 2,   1'b0, 0,  4'b0000, 0};
    vecs[11] = '{3'b011, 5'd0, 10'd6,   1'b0, 4'h3, 4'hC, 64'hABCD_0000_1230, 2'd1, 6,   1'b1, 2,  4'b0011, 0};

    repeat (2) @(negedge clk);
    chk("rst.tready", rx.o_axis_rx_tready, 0);
    chk("rst.wr_start", rx.o_wr_start, 0);
    chk("rst.data", rx.o_data, 0);
    chk("rst.addr", rx.o_addr, 0);
    chk("rst.misc", {rx.o_length, rx.o_dwbe, rx.o_dw_vld, rx.o_bar_hit, rx.o_drop, rx.o_rx_err}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst.tready_after", rx.o_axis_rx_tready, 1);
    clear_mon();

    for (int i = 0; i < 12; i++) begin
      send_tlp(vecs[i], 16'(16'hA000 + i), -1, hc);
      idle(8);
      check_case($sformatf("vec%0d", i), vecs[i], 16'(16'hA000 + i), hc);
      clear_mon();
    end

    // MRd then 4DW MWr back to back
    send_tlp(vecs[3], 16'hB000, -1, hc);
    send_tlp(vecs[4], 16'hB001, -1, hc);
    idle(8);
    chk("b2b1.drop", mon_drop, 1);
    chk("b2b1.bursts", mon_bursts, 1);
    chk("b2b1.beats", mon_data.size(), 1);
    check_beats("b2b1", vecs[4], 16'hB001);
    clear_mon();

    // two MWr back to back must form two separate bursts
    send_tlp(vecs[2], 16'hB100, -1, hc);
    send_tlp(vecs[6], 16'hB101, -1, hc);
    idle(8);
    chk("b2b2.bursts", mon_bursts, 2);
    chk("b2b2.beats", mon_data.size(), 3);
    chk("b2b2.drop", mon_drop, 0);
    clear_mon();

    // tvalid gap inside a 4DW payload
    send_tlp(vecs[2], 16'hC000, 2, hc);
    idle(8);
    chk("gap.err", mon_err, 1);
    chk("gap.beats", mon_data.size(), 2);
    chk("gap.bursts", mon_bursts, 2);
    check_beats("gap", vecs[2], 16'hC000);
    clear_mon();

    // reset in the middle of a 4DW MWr, then a normal write
    put_beat({32'h0000_0040, 32'h0000_0001, 32'h0000_00FF, 32'h6000_0008}, 2'd2, 1'b0, hc);
    put_beat({32'h4, 32'h3, 32'h2, 32'h1}, 2'd0, 1'b0, hc2);
    @(posedge clk);
    #1 chk("mid.ws_before", rx.o_wr_start, 1);
    rst_n = 1'b0;
    rx.i_axis_rx_tvalid = 1'b0;
    #1;
    chk("mid.ws", rx.o_wr_start, 0);
    chk("mid.out", {rx.o_addr, rx.o_length, rx.o_dw_vld, rx.o_axis_rx_tready}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    send_tlp(vecs[1], 16'hD000, -1, hc);
    idle(8);
    check_case("post_rst", vecs[1], 16'hD000, hc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
